spatz_vrf_wport_arbiter: RTL

Shares the single VRF write port between several vector execution units (e.g. VFU, VLSU, VSLDU). Each cycle it picks one pending write by round-robin, captures it in a one-entry output register that drives the VRF, and returns a per-requester write-accept pulse. This pulse is the `vrf_wvalid`-style acknowledgement the units use to advance their element counters and addresses. The block sits between the execution units and the VRF write port.

---
 rtl/spatz_vrf_wport_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/spatz_vrf_wport_arbiter.sv
// Round-robin arbiter sharing the single VRF write port between execution units.
// One-entry output register drives the VRF; per-unit accept pulses report grants.
module spatz_vrf_wport_arbiter #(
  parameter int unsigned NrReq     = 3,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NrReq-1:0]                     req_we_i,
  input  logic [NrReq-1:0][AddrWidth-1:0]      req_waddr_i,
  input  logic [NrReq-1:0][DataWidth-1:0]      req_wdata_i,
  input  logic [NrReq-1:0][DataWidth/8-1:0]    req_wbe_i,
  input  logic [NrReq-1:0][IdWidth-1:0]        req_id_i,
  output logic [NrReq-1:0]                     req_wvalid_o,
  output logic                                 vrf_we_o,
  output logic [AddrWidth-1:0]                 vrf_waddr_o,
  output logic [DataWidth-1:0]                 vrf_wdata_o,
  output logic [DataWidth/8-1:0]               vrf_wbe_o,
  output logic [IdWidth-1:0]                   vrf_id_o,
  input  logic                                 vrf_wack_i
);

  localparam int unsigned IdxW = (NrReq > 1) ? $clog2(NrReq) : 1;

  logic [IdxW-1:0]        rr_q;
  logic                   valid_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   data_q;
  logic [DataWidth/8-1:0] be_q;
  logic [IdWidth-1:0]     id_q;

  logic                   free;
  logic                   found;
  logic                   grant;
  logic [IdxW-1:0]        winner;
  logic [IdxW-1:0]        rr_next;

  // Draining and refilling in the same cycle is allowed.
  assign free = !valid_q || vrf_wack_i;

  always_comb begin
    int            idx;
    logic [IdxW-1:0] idx_w;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int i = 0; i < int'(NrReq); i++) begin
      idx = int'(rr_q) + i;
      if (idx >= int'(NrReq)) idx = idx - int'(NrReq);
      idx_w = idx[IdxW-1:0];
      if (!found && req_we_i[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
  end

  assign grant   = free && found;
  assign rr_next = (winner == IdxW'(NrReq - 1)) ? '0 : winner + IdxW'(1);

  // Grant pulse is forced low while reset is asserted.
  for (genvar gi = 0; gi < NrReq; gi++) begin : g_wvalid
    assign req_wvalid_o[gi] = rst_ni && grant && (winner == IdxW'(gi));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      id_q    <= '0;
    end else if (grant) begin
      rr_q    <= rr_next;
      valid_q <= 1'b1;
      addr_q  <= req_waddr_i[winner];
      data_q  <= req_wdata_i[winner];
      be_q    <= req_wbe_i[winner];
      id_q    <= req_id_i[winner];
    end else if (vrf_wack_i) begin
      valid_q <= 1'b0;
    end
  end

  assign vrf_we_o    = valid_q;
  assign vrf_waddr_o = addr_q;
  assign vrf_wdata_o = data_q;
  assign vrf_wbe_o   = be_q;
  assign vrf_id_o    = id_q;

endmodule
